sm_divider: RTL and testbench

- Sequential sign-magnitude divider. It is the inverse of the team's 16x16 sign-magnitude multiplier.
- Takes a 2W-bit sign-magnitude dividend (e.g. a MAC/product word) and a W-bit sign-magnitude divisor. Returns a W-bit quotient and a W-bit remainder in the same format.
- Used for normalisation/averaging steps in the DNN datapath.
- Fixed latency, one operation in flight.

---
 rtl/sm_divider.sv | 119 +++++++++++
 tb/tb_sm_divider.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sm_divider.sv
// sm_divider: sequential sign-magnitude restoring divider, 2W/W -> W quotient and remainder; optional rounding via SM_DIVIDER_ROUND_EN
module sm_divider #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           ovf,
  output logic           dbz
);
  localparam int CW = $clog2(W);
  typedef enum logic [2:0] {IDLE, CHK, DIV, SGN, OUT} state_t;
  state_t         state;
  logic [2*W-1:0] dvd;
  logic [W-1:0]   dvs;
  logic [W-2:0]   pr;
  logic [W-2:0]   low;
  logic [W-2:0]   qb;
  logic [CW-1:0]  cnt;
  logic           ovf_f;
  logic           dbz_f;
  logic [W-2:0]   vm;
  logic [W-1:0]   sh;
  logic           ge;
  logic [W-2:0]   diff;
  logic           err;
  logic [W-2:0]   q_m;
  logic [W-2:0]   r_m;
  logic           ovf_o;
`ifdef SM_DIVIDER_ROUND_EN
  logic [W-1:0]   qinc;
  logic           rnd;
  logic           sat;
`endif
  // restoring step datapath and sign/magnitude result formation
  always_comb begin
    vm = dvs[W-2:0];
    sh = {pr, low[W-2]};
    ge = sh >= {1'b0, vm};
    diff = sh[W-2:0] - vm;
    err = ovf_f | dbz_f;
    r_m = err ? '0 : pr;
`ifdef SM_DIVIDER_ROUND_EN
    qinc = {1'b0, qb} + W'(1);
    rnd = !err && ({pr, 1'b0} >= {1'b0, vm});
    sat = rnd & qinc[W-1];
    q_m = (err | sat) ? '1 : rnd ? qinc[W-2:0] : qb;
    ovf_o = ovf_f | sat;
`else
    q_m = err ? '1 : qb;
    ovf_o = ovf_f;
`endif
  end
  // control FSM with registered outputs; operands captured only in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dvd <= '0;
      dvs <= '0;
      pr <= '0;
      low <= '0;
      qb <= '0;
      cnt <= '0;
      ovf_f <= 1'b0;
      dbz_f <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      ovf <= 1'b0;
      dbz <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (en) begin
          dvd <= dividend;
          dvs <= divisor;
          busy <= 1'b1;
          state <= CHK;
        end
        CHK: begin
          dbz_f <= vm == '0;
          ovf_f <= (vm != '0) && (dvd[2*W-2:W-1] >= {1'b0, vm});
          pr <= dvd[2*W-3:W-1];
          low <= dvd[W-2:0];
          qb <= '0;
          cnt <= CW'(W-1);
          state <= DIV;
        end
        DIV: begin
          pr <= ge ? diff : sh[W-2:0];
          qb <= {qb[W-3:0], ge};
          low <= {low[W-3:0], 1'b0};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= SGN;
        end
        SGN: begin
          quotient <= {(dvd[2*W-1] ^ dvs[W-1]) & (|q_m), q_m};
          remainder <= {dvd[2*W-1] & (|r_m), r_m};
          ovf <= ovf_o;
          dbz <= dbz_f;
          done <= 1'b1;
          state <= OUT;
        end
        OUT: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sm_divider.sv
// tb_sm_divider: randomized scoreboard bench for sm_divider against an arithmetic reference model
module tb_sm_divider;
  localparam int W = 16;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [31:0]   dividend = '0;
  logic [15:0]   divisor = '0;
  logic [15:0]   quotient, remainder;
  logic          busy, done, ovf, dbz;
  typedef struct {logic [15:0] q; logic [15:0] r; logic ovf; logic dbz; int at;} exp_t;
  exp_t sb[$];
  int   cyc = 0;
  int   mleft = 0;
  logic rst_q = 1'b0;
  logic final_chk = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sm_divider #(.W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .ovf(ovf), .dbz(dbz)
  );

  always #5 clk = ~clk;

  // truncating (or rounded) sign-magnitude division computed with plain integer arithmetic
  function automatic exp_t model(input logic [31:0] a, input logic [15:0] b);
    longint dm, vm, qm, rm;
    exp_t e;
    dm = longint'(a[30:0]);
    vm = longint'(b[14:0]);
    e.dbz = (vm == 0);
    e.ovf = !e.dbz && (dm / vm) > 32767;
    if (e.dbz || e.ovf) begin
      qm = 32767;
      rm = 0;
    end else begin
      qm = dm / vm;
      rm = dm % vm;
`ifdef SM_DIVIDER_ROUND_EN
      if (2 * rm >= vm) qm = qm + 1;
      if (qm > 32767) begin
        qm = 32767;
        e.ovf = 1'b1;
      end
`endif
    end
    e.q = {(a[31] ^ b[15]) && qm != 0, 15'(qm)};
    e.r = {a[31] && rm != 0, 15'(rm)};
    e.at = 0;
    return e;
  endfunction

  // reference timing: an accepted request keeps the unit busy W+2 cycles, done after edge W+1
  always @(posedge clk) begin
    exp_t e;
    cyc <= cyc + 1;
    rst_q <= rst;
    if (rst) begin
      mleft <= 0;
      sb.delete();
    end else if (mleft > 0) begin
      mleft <= mleft - 1;
    end else if (en) begin
      e = model(dividend, divisor);
      e.at = cyc + 1 + W + 1;
      sb.push_back(e);
      mleft <= W + 2;
    end
  end

  // monitor: compares busy every cycle, pops the scoreboard on done, checks post-reset zeros
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (busy !== (mleft != 0)) begin
      errors++;
      $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, mleft != 0);
    end
    if (rst_q) begin
      checks++;
      if ({quotient, remainder, done, ovf, dbz, busy} !== '0) begin
        errors++;
        $display("FAIL reset_zero got q=%h r=%h done=%b ovf=%b dbz=%b busy=%b want all 0",
                 quotient, remainder, done, ovf, dbz, busy);
      end
    end else if (done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d got done=1 want 0", cyc);
      end else begin
        e = sb.pop_front();
        if (quotient !== e.q || remainder !== e.r || ovf !== e.ovf || dbz !== e.dbz || cyc != e.at) begin
          errors++;
          $display("FAIL result got q=%h r=%h ovf=%b dbz=%b cyc=%0d want q=%h r=%h ovf=%b dbz=%b cyc=%0d",
                   quotient, remainder, ovf, dbz, cyc, e.q, e.r, e.ovf, e.dbz, e.at);
        end
      end
    end
    if (final_chk) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL missing_done got %0d pending want 0", sb.size());
      end
    end
  end

  task automatic op(input logic [31:0] a, input logic [15:0] b);
    while (mleft != 0) @(negedge clk);
    dividend = a;
    divisor = b;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    dividend = $urandom;
    divisor = 16'($urandom);
  endtask

  task automatic rand_op();
    logic [31:0] a;
    logic [15:0] b;
    a = $urandom;
    b = 16'($urandom);
    case ($urandom_range(0, 3))
      0: a[30:15] = 16'($urandom_range(0, 3));
      1: begin a[30:20] = '0; b[14:8] = '0; end
      2: b[14:0] = 15'($urandom_range(0, 2));
      default: ;
    endcase
    op(a, b);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    op(32'h0000_03E8, 16'h0007);
    op(32'h8000_03E8, 16'h0007);
    op(32'h0000_1234, 16'h8000);
    op(32'h0000_7FFF, 16'h0001);
    op(32'h0000_8000, 16'h0001);
    op(32'h8000_0003, 16'h0007);
    op(32'h8000_0007, 16'h0007);
    op(32'h7FFF_FFFF, 16'h7FFF);
    op(32'h3FFF_7FFF, 16'h7FFF);
    op(32'h0000_0000, 16'h8005);
    for (int i = 0; i < 40; i++) rand_op();
    while (mleft != 0) @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 3 * (W + 3) + 2; i++) begin
      dividend = $urandom;
      dividend[30:20] = '0;
      divisor = 16'($urandom_range(1, 16'hFFFF));
      @(negedge clk);
    end
    en = 1'b0;
    while (mleft != 0) @(negedge clk);
    op(32'h0001_2345, 16'h0123);
    while (mleft != 10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 4) @(negedge clk);
    op(32'h8000_1000, 16'h8010);
    while (mleft != 0) @(negedge clk);
    final_chk = 1'b1;
    @(negedge clk);
    final_chk = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
